// File: rtl/shift_add_mult_if.sv
// Operand/product handshake bundle for shift_add_mult.
// master drives operands and out_ready; slave is the multiplier.
interface shift_add_mult_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] p;
   logic               busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, p, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, p, busy
   );
endinterface

// File: rtl/shift_add_mult.sv
// Iterative shift-add multiplier, one partial product per cycle.
// Define MULT_SIGNED_EN for two's-complement operands.
module shift_add_mult #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   shift_add_mult_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]         state;
   logic [WIDTH-1:0]   a_reg;
   logic [2*WIDTH:0]   acc;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] p_reg;

   logic [WIDTH:0]     upper;
   logic [2*WIDTH:0]   acc_nx;
   logic [WIDTH-1:0]   a_in;
   logic [WIDTH-1:0]   b_in;
   logic [2*WIDTH-1:0] res;
   logic               last;

`ifdef MULT_SIGNED_EN
   logic sign;

   // -2^(W-1) negates to itself, which reads correctly as unsigned
   always_comb begin
      a_in = bus.a[WIDTH-1] ? -bus.a : bus.a;
      b_in = bus.b[WIDTH-1] ? -bus.b : bus.b;
      res  = sign ? -acc_nx[2*WIDTH-1:0]
                  : acc_nx[2*WIDTH-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign <= 1'b0;
      end else if (state == IDLE && bus.in_valid) begin
         sign <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      end
   end
`else
   always_comb begin
      a_in = bus.a;
      b_in = bus.b;
      res  = acc_nx[2*WIDTH-1:0];
   end
`endif

   // carry of the add lands in acc[2W] before the shift
   always_comb begin
      upper = acc[2*WIDTH:WIDTH];
      if (acc[0]) begin
         upper = acc[2*WIDTH:WIDTH] + {1'b0, a_reg};
      end
      acc_nx = {1'b0, upper, acc[WIDTH-1:1]};
      last   = (count == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         a_reg <= '0;
         acc   <= '0;
         count <= '0;
         p_reg <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_reg <= a_in;
                  acc   <= {{(WIDTH+1){1'b0}}, b_in};
                  count <= '0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               acc   <= acc_nx;
               count <= count + 1'b1;
               if (last) begin
                  p_reg <= res;
                  state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state == BUSY) || (state == DONE);
   assign bus.p         = p_reg;
endmodule
